counter_ctrl: RTL and testbench

- Upstream control stage for the WIDTH-bit up-counter.
- Accepts commands over a valid/ready handshake: LOAD value, START, STOP.
- In RUN, generates the counter's en strobe through a programmable prescaler and drives its load/data_in.
- Consumes the counter's registered carry_out pulse to keep a saturating overflow tally and a sticky interrupt.

---
 rtl/counter_ctrl_if.sv | 28 ++
 rtl/counter_ctrl.sv | 127 ++++++++++++
 tb/tb_counter_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Command channel for counter_ctrl: valid/ready handshake carrying
// opcode, load value and prescale. Master drives, slave answers ready.
interface counter_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [PRE_W-1:0] prescale;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output prescale,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  prescale,
        output cmd_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// Upstream control stage for a WIDTH-bit up-counter.
// Ports: clk, rst (async, active-high); cmd (counter_ctrl_if.slave:
//   cmd_valid/cmd_ready/cmd_op/cmd_data/prescale); carry_in, irq_clr in;
//   cnt_en, cnt_load, cnt_data to the counter; ovf_count, irq, busy out.
// Optional macro CNT_CTRL_ONESHOT_EN: carry_in while running auto-stops.
module counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8,
    parameter int OVF_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    counter_ctrl_if.slave    cmd,
    input  logic             carry_in,
    input  logic             irq_clr,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    output logic [OVF_W-1:0] ovf_count,
    output logic             irq,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    state_t           state;
    logic             run_q;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] prescale_q;
    logic [WIDTH-1:0] data_q;
    logic [OVF_W-1:0] ovf_q;
    logic             irq_q;

    logic accept;
    logic pre_hit;
    logic auto_stop;

    assign accept  = cmd.cmd_valid & cmd.cmd_ready;
    assign pre_hit = (pre_cnt == prescale_q);

`ifdef CNT_CTRL_ONESHOT_EN
    assign auto_stop = carry_in & (state == S_RUN);
`else
    assign auto_stop = 1'b0;
`endif

    // Ready depends on state only, never on cmd_valid.
    assign cmd.cmd_ready = (state != S_LOAD);
    assign cnt_load      = (state == S_LOAD);
    assign cnt_en        = (state == S_RUN) & pre_hit;
    assign busy          = (state != S_IDLE);
    assign cnt_data      = data_q;
    assign ovf_count     = ovf_q;
    assign irq           = irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            run_q      <= 1'b0;
            pre_cnt    <= '0;
            prescale_q <= '0;
            data_q     <= '0;
            ovf_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            // A LOAD restarts the tally; its clear beats a same-edge carry.
            if (accept && cmd.cmd_op == OP_LOAD) begin
                ovf_q <= '0;
            end else if (carry_in && ovf_q != '1) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end

            // Set beats clear.
            if (carry_in) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end

            case (state)
                S_LOAD: state <= run_q ? S_RUN : S_IDLE;
                S_RUN: begin
                    if (pre_hit) pre_cnt <= '0;
                    else         pre_cnt <= pre_cnt + PRE_W'(1);
                end
                default: ;
            endcase

            if (auto_stop) begin
                state <= S_IDLE;
                run_q <= 1'b0;
            end

            // Accepted commands override the auto-stop above.
            if (accept) begin
                case (cmd.cmd_op)
                    OP_LOAD: begin
                        state   <= S_LOAD;
                        data_q  <= cmd.cmd_data;
                        pre_cnt <= '0;
                        run_q   <= run_q;
                    end
                    OP_START: begin
                        state      <= S_RUN;
                        prescale_q <= cmd.prescale;
                        pre_cnt    <= '0;
                        run_q      <= 1'b1;
                    end
                    OP_STOP: begin
                        state <= S_IDLE;
                        run_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: behavioural model plus
// directed literal checks and randomized command traffic.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       carry_in;
    logic       irq_clr = 1'b0;
    logic       cnt_en, cnt_load, irq, busy;
    logic [7:0] cnt_data;
    logic [3:0] ovf_count;

    counter_ctrl_if #(.WIDTH(8), .PRE_W(8)) ifc ();

    counter_ctrl #(.WIDTH(8), .PRE_W(8), .OVF_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (ifc),
        .carry_in (carry_in),
        .irq_clr  (irq_clr),
        .cnt_en   (cnt_en),
        .cnt_load (cnt_load),
        .cnt_data (cnt_data),
        .ovf_count(ovf_count),
        .irq      (irq),
        .busy     (busy)
    );

    always #5 clk = ~clk;

`ifdef CNT_CTRL_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    // Downstream counter, used to produce realistic carry pulses.
    logic [7:0] ctr_val;
    logic       ctr_carry;
    bit         ctr_mode = 1'b0;
    logic       rnd_carry = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_val   <= 8'h00;
            ctr_carry <= 1'b0;
        end else begin
            ctr_carry <= cnt_en && !cnt_load && ctr_val == 8'hFF;
            if (cnt_load)    ctr_val <= cnt_data;
            else if (cnt_en) ctr_val <= ctr_val + 8'h01;
        end
    end

    assign carry_in = ctr_mode ? ctr_carry : rnd_carry;

    // Model: run flag, loading flag, RUN cycles since the last anchor.
    bit  m_run, m_loading, m_irq;
    int  m_ticks, m_ps, m_ovf;
    logic [7:0] m_data;

    bit         s_valid, s_carry, s_clr;
    logic [1:0] s_op;
    logic [7:0] s_data, s_ps;

    int  total = 0;
    int  bad = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_loading = 0; m_irq = 0;
        m_ticks = 0; m_ps = 0; m_ovf = 0; m_data = 8'h00;
    endtask

    function automatic bit model_en();
        return !m_loading && m_run && (m_ticks % (m_ps + 1)) == m_ps;
    endfunction

    task automatic model_step();
        bit acc;
        bit running;
        acc     = s_valid && !m_loading;
        running = m_run && !m_loading;
        if (acc && s_op == 2'b01)      m_ovf = 0;
        else if (s_carry && m_ovf < 15) m_ovf++;
        if (s_carry)    m_irq = 1;
        else if (s_clr) m_irq = 0;
        if (m_loading) begin
            m_loading = 0;
        end else begin
            if (running) m_ticks++;
            if (ONESHOT && s_carry && running && !(acc && s_op != 2'b00))
                m_run = 0;
            if (acc) begin
                case (s_op)
                    2'b01: begin
                        m_data = s_data; m_loading = 1; m_ticks = 0;
                    end
                    2'b10: begin
                        m_run = 1; m_ps = int'(s_ps); m_ticks = 0;
                    end
                    2'b11: m_run = 0;
                    default: ;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", ifc.cmd_ready, !m_loading);
            chk("cnt_load", cnt_load, m_loading);
            chk("busy", busy, m_loading || m_run);
            chk("cnt_en", cnt_en, model_en());
            chk("cnt_data", cnt_data, m_data);
            chk("ovf_count", ovf_count, m_ovf);
            chk("irq", irq, m_irq);
        end
    end

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input bit v, input logic [1:0] op,
                         input logic [7:0] d, input logic [7:0] ps,
                         input bit c, input bit clr);
        ifc.cmd_valid = v;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        ifc.prescale  = ps;
        rnd_carry     = c;
        irq_clr       = clr;
        #1;
        s_valid = ifc.cmd_valid; s_op = ifc.cmd_op;
        s_data = ifc.cmd_data; s_ps = ifc.prescale;
        s_carry = carry_in; s_clr = irq_clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic nop();
        drive(0, 2'b00, 8'h00, 8'h00, 0, 0);
    endtask

    initial begin
        int  n_en;
        bit  got;
        ifc.cmd_valid = 0; ifc.cmd_op = 2'b00;
        ifc.cmd_data = 8'h00; ifc.prescale = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_ready", ifc.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_data", cnt_data, 8'h00);
        chk_en = 1;

        // LOAD 0xF0 from IDLE.
        drive(1, 2'b01, 8'hF0, 8'h00, 0, 0);
        chk("ld_load", cnt_load, 1);
        chk("ld_ready", ifc.cmd_ready, 0);
        chk("ld_data", cnt_data, 8'hF0);
        nop();
        chk("ld_done_load", cnt_load, 0);
        chk("ld_done_busy", busy, 0);

        // START prescale=3: en at T+4, T+8, T+12.
        drive(1, 2'b10, 8'h00, 8'd3, 0, 0);
        n_en = 0;
        for (int k = 0; k < 13; k++) begin
            chk("ps3_en", cnt_en, (k % 4) == 3);
            n_en += int'(cnt_en);
            nop();
        end
        chk("ps3_count", n_en, 3);
        drive(1, 2'b11, 8'h00, 8'h00, 0, 0);
        n_en = 0;
        for (int k = 0; k < 8; k++) begin
            n_en += int'(cnt_en);
            nop();
        end
        chk("stop_no_en", n_en, 0);

        // prescale=0, LOAD 0xFE mid-run, counter wraps.
        drive(1, 2'b10, 8'h00, 8'd0, 0, 0);
        chk("ps0_en", cnt_en, 1);
        ctr_mode = 1;
        drive(1, 2'b01, 8'hFE, 8'h00, 0, 0);
        chk("runld_en", cnt_en, 0);
        chk("runld_load", cnt_load, 1);
        nop();
        chk("resume_en", cnt_en, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            got = carry_in;
            nop();
        end
        chk("carry_seen", got, 1);
        chk("wrap_ovf", ovf_count, 1);
        chk("wrap_irq", irq, 1);
        ctr_mode = 0;
        drive(1, 2'b11, 8'h00, 8'h00, 0, 0);

        // Saturation and irq priority.
        for (int i = 0; i < 20; i++) drive(0, 2'b00, 8'h00, 8'h00, 1, 0);
        chk("sat_ovf", ovf_count, 15);
        drive(0, 2'b00, 8'h00, 8'h00, 1, 1);
        chk("irq_set_wins", irq, 1);
        drive(0, 2'b00, 8'h00, 8'h00, 0, 1);
        chk("irq_clr", irq, 0);

`ifdef CNT_CTRL_ONESHOT_EN
        drive(1, 2'b01, 8'hFF, 8'h00, 0, 0);
        nop();
        ctr_mode = 1;
        drive(1, 2'b10, 8'h00, 8'd0, 0, 0);
        for (int i = 0; i < 6; i++) nop();
        chk("os_busy", busy, 0);
        chk("os_ctr", ctr_val, 8'h01);
        ctr_mode = 0;
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) != 0, 2'($urandom),
                  8'($urandom),
                  ($urandom_range(7) == 0) ? 8'($urandom_range(9))
                                           : 8'($urandom_range(3)),
                  $urandom_range(9) == 0, $urandom_range(5) == 0);
        end

        // Asynchronous reset mid-RUN, prescale=5.
        drive(1, 2'b01, 8'h5A, 8'h00, 1, 0);
        nop();
        drive(1, 2'b10, 8'h00, 8'd5, 0, 0);
        for (int i = 0; i < 5; i++) nop();
        chk("pre_rst_en", cnt_en, 1);
        #2;
        chk_en = 0;
        rst = 1;
        model_reset();
        #1;
        chk("arst_en", cnt_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", ifc.cmd_ready, 1);
        chk("arst_load", cnt_load, 0);
        chk("arst_data", cnt_data, 8'h00);
        chk("arst_ovf", ovf_count, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        for (int i = 0; i < 4; i++) nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
